// File: rtl/reg_bank_arbiter.sv
// DEPTH x WIDTH register bank shared by NUM_REQ round-robin write requesters,
// with one registered read port (1-cycle latency, read-before-write ordering).
module reg_bank_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 8,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int GID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [GID_W-1:0]          grant_id,
    output logic                      wr_err,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid
);

    logic [WIDTH-1:0]  bank [DEPTH];
    logic [GID_W-1:0]  ptr;
    logic [GID_W-1:0]  gnt_idx;
    logic              gnt_found;
    logic              gnt_any;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              wr_ok;
    logic              rd_ok;

    // Scan from ptr upward (with wrap) for the first valid requester.
    always_comb begin : arb_scan
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!gnt_found && req_valid[GID_W'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = GID_W'(idx);
            end
        end
    end

    // No grant is offered while reset is held, so nothing handshakes mid-reset.
    assign gnt_any  = gnt_found & rst_n;
    assign grant_id = gnt_any ? gnt_idx : '0;

    always_comb begin
        req_ready = '0;
        if (gnt_any)
            req_ready[gnt_idx] = 1'b1;
    end

    assign wr_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign wr_data = req_data[gnt_idx*WIDTH +: WIDTH];

    // Address range checks only exist when DEPTH leaves unused codes.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_range
            assign wr_ok = 1'b1;
            assign rd_ok = 1'b1;
        end else begin : g_part_range
            assign wr_ok = (wr_addr < ADDR_W'(DEPTH));
            assign rd_ok = (rd_addr < ADDR_W'(DEPTH));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            wr_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                bank[i] <= '0;
        end else begin
            wr_err <= gnt_any & ~wr_ok;
            if (gnt_any) begin
                ptr <= (gnt_idx == GID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                if (wr_ok)
                    bank[wr_addr] <= wr_data;
            end
        end
    end

    // Reads sample the bank before this edge's write lands, so they see the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_ok ? bank[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter (DEPTH=6 so out-of-range codes exist):
// driver pushes model expectations, negedge monitor pops and compares.
module tb_reg_bank_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int D  = 6;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*W-1:0]  req_data = '0;
    logic [N-1:0]    req_ready;
    logic [1:0]      grant_id;
    logic            wr_err;
    logic            rd_en = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic [W-1:0]    rd_data;
    logic            rd_valid;

    reg_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .grant_id(grant_id),
        .wr_err(wr_err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    typedef struct { logic [N-1:0] rdy; logic [1:0] id; } gnt_t;
    typedef struct { int due; logic [W-1:0] d; } rd_t;
    gnt_t gntq[$];
    rd_t  rdq[$];
    int   errq[$];

    // Reference model: plain array bank plus a round-robin pointer.
    logic [W-1:0] mbank [D];
    int           mptr;

    function automatic int mgnt(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    task automatic mreset();
        for (int i = 0; i < D; i++) mbank[i] = '0;
        mptr = 0;
        gntq.delete(); rdq.delete(); errq.delete();
    endtask

    // Driver-side stimulus state
    logic [N-1:0]  v;
    logic [AW-1:0] a [N];
    logic [W-1:0]  d [N];
    logic          re;
    logic [AW-1:0] ra;
    int            lastg;

    // Called just after a posedge: apply inputs, predict, advance one cycle.
    task automatic step();
        gnt_t ge;
        rd_t  rexp;
        int   g;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_data[i*W +: W]   = d[i];
        end
        req_valid = v;
        rd_en     = re;
        rd_addr   = ra;
        g = mgnt(v);
        ge.rdy = '0;
        ge.id  = '0;
        if (g >= 0) begin
            ge.rdy[g] = 1'b1;
            ge.id     = 2'(g);
        end
        gntq.push_back(ge);
        if (re) begin
            rexp.due = cyc + 1;
            rexp.d   = (int'(ra) < D) ? mbank[ra] : '0;
            rdq.push_back(rexp);
        end
        if (g >= 0) begin
            if (int'(a[g]) < D) mbank[a[g]] = d[g];
            else errq.push_back(cyc + 1);
            mptr = (g + 1) % N;
        end
        lastg = g;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        v = '0; re = 1'b0; ra = '0;
        for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
    endtask

    task automatic wr1(input int r, input int ad, input logic [W-1:0] dt);
        idle();
        v[r] = 1'b1; a[r] = AW'(ad); d[r] = dt;
    endtask

    // Monitor: grant checked every cycle, registered outputs checked against due cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            gnt_t ge;
            logic rexp_v, eexp_v;
            chk("ready_onehot", ($countones(req_ready) <= 1), 1);
            chk("ready_without_valid", req_ready & ~req_valid, 0);
            if (gntq.size() > 0) begin
                ge = gntq.pop_front();
                chk("req_ready", req_ready, ge.rdy);
                chk("grant_id", grant_id, ge.id);
            end
            rexp_v = (rdq.size() > 0) && (rdq[0].due == cyc);
            chk("rd_valid", rd_valid, rexp_v);
            if (rexp_v) begin
                rd_t re_e;
                re_e = rdq.pop_front();
                chk("rd_data", rd_data, re_e.d);
            end else if (rdq.size() > 0 && rdq[0].due < cyc) begin
                void'(rdq.pop_front());
            end
            eexp_v = (errq.size() > 0) && (errq[0] == cyc);
            chk("wr_err", wr_err, eexp_v);
            if (eexp_v) void'(errq.pop_front());
        end
    end

    logic [N-1:0]  pend;
    logic [AW-1:0] pa [N];
    logic [W-1:0]  pd [N];

    task automatic random_phase(input int ncyc);
        pend = '0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i] = 1'b1;
                        pa[i]   = AW'($urandom_range(0, 7));
                        pd[i]   = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            v = pend;
            for (int i = 0; i < N; i++) begin a[i] = pa[i]; d[i] = pd[i]; end
            re = 1'($urandom_range(0, 1));
            ra = AW'($urandom_range(0, 7));
            step();
            if (lastg >= 0) pend[lastg] = 1'b0;
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) begin
            idle(); re = 1'b1; ra = AW'(i);
            step();
        end
    endtask

    initial begin
        mreset();
        idle();
        // Reset held with every requester asking
        req_valid = 4'hF;
        rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        read_all();

        // Single write then read back
        wr1(0, 3, 32'hDEAD_BEEF); step();
        idle(); re = 1'b1; ra = 3; step();

        // Round robin: bring ptr to 0, then all four held for 8 cycles
        wr1(3, 1, 32'h1111_0000); step();
        for (int c = 0; c < 8; c++) begin
            v = 4'hF;
            for (int i = 0; i < N; i++) begin a[i] = AW'(i); d[i] = $urandom; end
            re = 1'b0;
            step();
        end

        // Skip: ptr=2 with only req0/req1 valid
        wr1(1, 2, 32'h2222_2222); step();
        idle(); v = 4'b0011; a[0] = 4; d[0] = 32'hA0; a[1] = 0; d[1] = 32'hA1; step();
        idle(); v = 4'b0010; a[1] = 0; d[1] = 32'hA1; step();

        // Read during write to the same address
        wr1(2, 5, 32'h1); step();
        wr1(0, 5, 32'h2); re = 1'b1; ra = 5; step();
        idle(); re = 1'b1; ra = 5; step();

        // Out of range writes leave the bank alone
        wr1(1, 7, 32'hBAD0_0007); step();
        wr1(2, 6, 32'hBAD0_0006); step();
        idle(); step();
        read_all();

        random_phase(400);
        read_all();

        // Async reset mid-burst while read, error and grant are all active
        wr1(0, 3, 32'hDEAD_BEEF); step();
        wr1(0, 7, 32'h7); re = 1'b1; ra = 3; step();
        req_valid = 4'hF;
        #1 rst_n = 1'b0;
        mreset();
        #1;
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_grant_id", grant_id, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_wr_err", wr_err, 0);
        chk("midrst_rd_data", rd_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        read_all();
        random_phase(150);
        read_all();

        idle(); step(); step();
        #10;
        chk("rd_queue_drained", rdq.size(), 0);
        chk("err_queue_drained", errq.size(), 0);
        chk("gnt_queue_drained", gntq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
